// File: rtl/target_port.sv
// target_port: serial bus target that deserialises address/write data and serialises read data.
// Ports:
//   clk, rst                         clock, asynchronous active-high reset
//   bus_data_in/_valid, bus_mode     serial input bit, its valid strobe, 1=address phase 0=data phase
//   bus_init_rw, bus_init_ready      1=write/0=read (taken with first address bit), initiator ready for read data
//   bus_data_out/_valid              serial read data (LSB first) and its drive enable
//   target_ack, target_split         one-cycle completion and split pulses
//   dev_addr/_valid, dev_rw          deserialised address, update pulse, latched direction
//   dev_wdata/_valid                 deserialised write data and update pulse
//   dev_done                         device finished the write
//   dev_rdata/_valid, dev_split_req  read data handshake and split request from the device
module target_port #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  bus_data_in,
  input  logic                  bus_data_in_valid,
  input  logic                  bus_mode,
  input  logic                  bus_init_rw,
  input  logic                  bus_init_ready,
  output logic                  bus_data_out,
  output logic                  bus_data_out_valid,
  output logic                  target_ack,
  output logic                  target_split,
  output logic [ADDR_WIDTH-1:0] dev_addr,
  output logic                  dev_addr_valid,
  output logic                  dev_rw,
  output logic [DATA_WIDTH-1:0] dev_wdata,
  output logic                  dev_wdata_valid,
  input  logic                  dev_done,
  input  logic [DATA_WIDTH-1:0] dev_rdata,
  input  logic                  dev_rdata_valid,
  input  logic                  dev_split_req
);
  localparam int MW = ADDR_WIDTH > DATA_WIDTH ? ADDR_WIDTH : DATA_WIDTH;
  localparam int CW = $clog2(MW + 1);
  typedef enum logic [2:0] {IDLE, ADDR, WDATA, WR_WAIT, RD_WAIT, RD_TX} state_t;
  state_t                state_q;
  logic [CW-1:0]         cnt_q;
  logic [DATA_WIDTH-1:0] tx_q;
  logic                  have_q;
  logic                  split_seen_q;
  logic                  accept;
  // A bit counts only if its mode matches the phase the FSM is collecting.
  assign accept = bus_data_in_valid &&
                  ((state_q == IDLE || state_q == ADDR) ? bus_mode : (state_q == WDATA && !bus_mode));
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q            <= IDLE;
      cnt_q              <= '0;
      tx_q               <= '0;
      have_q             <= 1'b0;
      split_seen_q       <= 1'b0;
      bus_data_out       <= 1'b0;
      bus_data_out_valid <= 1'b0;
      target_ack         <= 1'b0;
      target_split       <= 1'b0;
      dev_addr           <= '0;
      dev_addr_valid     <= 1'b0;
      dev_rw             <= 1'b0;
      dev_wdata          <= '0;
      dev_wdata_valid    <= 1'b0;
    end else begin
      dev_addr_valid  <= 1'b0;
      dev_wdata_valid <= 1'b0;
      target_ack      <= 1'b0;
      target_split    <= 1'b0;
      // Re-arm the split pulse only once the request has dropped.
      if (!dev_split_req) split_seen_q <= 1'b0;
      case (state_q)
        IDLE: if (accept) begin
          dev_addr <= ADDR_WIDTH'(bus_data_in);
          dev_rw   <= bus_init_rw;
          cnt_q    <= CW'(1);
          state_q  <= ADDR;
        end
        ADDR: if (accept) begin
          dev_addr <= dev_addr | (ADDR_WIDTH'(bus_data_in) << cnt_q);
          if (cnt_q == CW'(ADDR_WIDTH - 1)) begin
            cnt_q          <= '0;
            dev_addr_valid <= 1'b1;
            have_q         <= 1'b0;
            state_q        <= dev_rw ? WDATA : RD_WAIT;
          end else cnt_q <= cnt_q + 1'b1;
        end
        WDATA: if (accept) begin
          // First data bit clears the previous transaction's word.
          dev_wdata <= (cnt_q == '0 ? '0 : dev_wdata) | (DATA_WIDTH'(bus_data_in) << cnt_q);
          if (cnt_q == CW'(DATA_WIDTH - 1)) begin
            cnt_q           <= '0;
            dev_wdata_valid <= 1'b1;
            state_q         <= WR_WAIT;
          end else cnt_q <= cnt_q + 1'b1;
        end
        WR_WAIT: if (dev_done) begin
          target_ack <= 1'b1;
          state_q    <= IDLE;
        end
        RD_WAIT: begin
          if (have_q) begin
            if (bus_init_ready) begin
              bus_data_out_valid <= 1'b1;
              bus_data_out       <= tx_q[0];
              tx_q               <= tx_q >> 1;
              cnt_q              <= CW'(1);
              state_q            <= RD_TX;
            end
          end else if (dev_rdata_valid) begin
            tx_q   <= dev_rdata;
            have_q <= 1'b1;
          end else if (dev_split_req && !split_seen_q) begin
            target_split <= 1'b1;
            split_seen_q <= 1'b1;
          end
        end
        RD_TX: begin
          if (cnt_q == CW'(DATA_WIDTH)) begin
            bus_data_out_valid <= 1'b0;
            bus_data_out       <= 1'b0;
            target_ack         <= 1'b1;
            have_q             <= 1'b0;
            cnt_q              <= '0;
            state_q            <= IDLE;
          end else begin
            bus_data_out <= tx_q[0];
            tx_q         <= tx_q >> 1;
            cnt_q        <= cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_target_port.sv
// tb_target_port: randomized transaction-level check of target_port against expected bus behaviour.
module tb_target_port;
  localparam int AW = 16;
  localparam int DW = 8;
  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          bus_data_in = 1'b0, bus_data_in_valid = 1'b0, bus_mode = 1'b0;
  logic          bus_init_rw = 1'b0, bus_init_ready = 1'b0;
  logic          bus_data_out, bus_data_out_valid, target_ack, target_split;
  logic [AW-1:0] dev_addr;
  logic          dev_addr_valid, dev_rw;
  logic [DW-1:0] dev_wdata;
  logic          dev_wdata_valid;
  logic          dev_done = 1'b0;
  logic [DW-1:0] dev_rdata = '0;
  logic          dev_rdata_valid = 1'b0, dev_split_req = 1'b0;
  int            n_chk = 0, n_fail = 0;
  int            n_av, n_wv, n_ack, n_split, n_runs, n_stray;
  logic [AW-1:0] last_addr;
  logic [DW-1:0] last_wdata;
  logic          prev_v = 1'b0;
  logic          rx[$];

  target_port #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst),
    .bus_data_in(bus_data_in), .bus_data_in_valid(bus_data_in_valid), .bus_mode(bus_mode),
    .bus_init_rw(bus_init_rw), .bus_init_ready(bus_init_ready),
    .bus_data_out(bus_data_out), .bus_data_out_valid(bus_data_out_valid),
    .target_ack(target_ack), .target_split(target_split),
    .dev_addr(dev_addr), .dev_addr_valid(dev_addr_valid), .dev_rw(dev_rw),
    .dev_wdata(dev_wdata), .dev_wdata_valid(dev_wdata_valid),
    .dev_done(dev_done), .dev_rdata(dev_rdata), .dev_rdata_valid(dev_rdata_valid),
    .dev_split_req(dev_split_req)
  );

  always #5 clk = ~clk;

  // Observe the bus on the falling edge, away from the DUT's active edge.
  always @(negedge clk) begin
    if (dev_addr_valid) begin n_av++; last_addr = dev_addr; end
    if (dev_wdata_valid) begin n_wv++; last_wdata = dev_wdata; end
    if (target_ack) n_ack++;
    if (target_split) n_split++;
    if (bus_data_out_valid) rx.push_back(bus_data_out);
    if (bus_data_out_valid && !prev_v) n_runs++;
    if (!bus_data_out_valid && bus_data_out) n_stray++;
    prev_v = bus_data_out_valid;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear();
    n_av = 0; n_wv = 0; n_ack = 0; n_split = 0; n_runs = 0; n_stray = 0;
    rx.delete();
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Optionally precede the real bit with gaps and wrong-mode bits that must be ignored.
  task automatic send_bit(input logic b, input logic mode, input logic rw, input bit noisy);
    if (noisy) repeat ($urandom_range(0, 2)) begin
      tick();
      bus_data_in_valid = 1'($urandom_range(0, 1));
      bus_mode = ~mode;
      bus_data_in = 1'($urandom);
      bus_init_rw = 1'($urandom);
    end
    tick();
    bus_data_in_valid = 1'b1;
    bus_mode = mode;
    bus_data_in = b;
    bus_init_rw = rw;
  endtask

  task automatic idle_bus();
    tick();
    bus_data_in_valid = 1'b0;
    bus_data_in = 1'b0;
  endtask

  task automatic send_addr(input logic [AW-1:0] a, input logic rw, input bit noisy);
    for (int i = 0; i < AW; i++) send_bit(a[i], 1'b1, rw, noisy);
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input bit noisy);
    clear();
    send_addr(a, 1'b1, noisy);
    for (int i = 0; i < DW; i++) send_bit(d[i], 1'b0, 1'b1, noisy);
    idle_bus();
    repeat ($urandom_range(1, 4)) tick();
    chk("wr_addr_pulses", n_av, 1);
    chk("wr_addr", last_addr, a);
    chk("wr_rw", dev_rw, 1);
    chk("wr_data_pulses", n_wv, 1);
    chk("wr_data", last_wdata, d);
    chk("wr_early_ack", n_ack, 0);
    dev_done = 1'b1;
    tick();
    dev_done = 1'b0;
    repeat (3) tick();
    chk("wr_ack", n_ack, 1);
    chk("wr_no_txout", rx.size(), 0);
  endtask

  task automatic do_read(input logic [AW-1:0] a, input logic [DW-1:0] d, input int delay,
                         input int split_cyc, input bit noisy);
    logic [DW-1:0] v;
    int k;
    clear();
    bus_init_ready = (delay == 0);
    send_addr(a, 1'b0, noisy);
    idle_bus();
    tick();
    chk("rd_addr_pulses", n_av, 1);
    chk("rd_addr", last_addr, a);
    chk("rd_rw", dev_rw, 0);
    if (split_cyc > 0) begin
      dev_split_req = 1'b1;
      repeat (split_cyc) tick();
      dev_split_req = 1'b0;
      // Stray input bits here must be ignored.
      bus_data_in_valid = 1'b1; bus_mode = 1'b1; bus_data_in = 1'b1;
      tick();
      bus_data_in_valid = 1'b0;
      tick();
    end
    chk("rd_split", n_split, split_cyc > 0 ? 1 : 0);
    dev_rdata = d;
    dev_rdata_valid = 1'b1;
    dev_split_req = 1'($urandom);
    tick();
    dev_rdata_valid = 1'b0;
    dev_split_req = 1'b0;
    dev_rdata = DW'($urandom);
    if (delay > 0) begin
      repeat (delay) tick();
      chk("rd_held_until_ready", rx.size(), 0);
      bus_init_ready = 1'b1;
    end
    k = 0;
    while (n_ack == 0 && k < 100) begin
      tick();
      if (rx.size() > 0) bus_init_ready = 1'($urandom);
      k++;
    end
    bus_init_ready = 1'b0;
    repeat (2) tick();
    chk("rd_ack", n_ack, 1);
    chk("rd_len", rx.size(), DW);
    v = '0;
    for (int i = 0; i < DW && i < rx.size(); i++) v[i] = rx[i];
    chk("rd_data", v, d);
    chk("rd_runs", n_runs, 1);
    chk("rd_split_total", n_split, split_cyc > 0 ? 1 : 0);
    chk("rd_out_idle_zero", n_stray, 0);
  endtask

  initial begin
    clear();
    repeat (3) tick();
    chk("rst_addr", dev_addr, 0);
    chk("rst_wdata", dev_wdata, 0);
    chk("rst_rw", dev_rw, 0);
    chk("rst_outs", {bus_data_out, bus_data_out_valid, target_ack, target_split,
                     dev_addr_valid, dev_wdata_valid}, 0);
    rst = 1'b0;
    tick();
    do_write(16'hA55A, 8'h3C, 1'b0);
    do_read(16'hA55A, 8'h96, 0, 0, 1'b0);
    do_read(16'hA55A, 8'h96, 5, 0, 1'b0);
    do_write(16'hA55A, 8'h3C, 1'b1);
    // Abort a transaction part-way through the address with an asynchronous reset.
    clear();
    for (int i = 0; i < 7; i++) send_bit(1'b1, 1'b1, 1'b1, 1'b0);
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    chk("midrst_addr", dev_addr, 0);
    chk("midrst_rw", dev_rw, 0);
    bus_data_in_valid = 1'b0;
    tick();
    rst = 1'b0;
    do_write(16'h1234, 8'hFF, 1'b0);
    do_read(16'hBEEF, 8'h5A, 1, 3, 1'b0);
    for (int t = 0; t < 20; t++) begin
      if ($urandom_range(0, 1) == 1)
        do_write(AW'($urandom), DW'($urandom), 1'($urandom));
      else
        do_read(AW'($urandom), DW'($urandom), $urandom_range(0, 4), $urandom_range(0, 4), 1'($urandom));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/target_port.md
TARGET_PORT -- requirements
Module: target_port

Interface
REQ-001 Parameter ADDR_WIDTH, default 16, address bits received per transaction.
REQ-002 Parameter DATA_WIDTH, default 8, data bits per write or read.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 bus_data_in  input  1  serial bus bit from the initiator port.
REQ-006 bus_data_in_valid  input  1  bus_data_in carries a valid bit this cycle.
REQ-007 bus_mode  input  1  1 = address phase bit, 0 = data phase bit.
REQ-008 bus_init_rw  input  1  1 = write, 0 = read; sampled with first address bit.
REQ-009 bus_init_ready  input  1  initiator can accept read data.
REQ-010 bus_data_out  output  1  serial read-data bit, LSB first.
REQ-011 bus_data_out_valid  output  1  bus_data_out is driven and valid (tri-state enable).
REQ-012 target_ack  output  1  one-cycle transaction-complete pulse to the bus.
REQ-013 target_split  output  1  one-cycle split pulse to the bus.
REQ-014 dev_addr  output  ADDR_WIDTH  deserialised address, held until next transaction.
REQ-015 dev_addr_valid  output  1  one-cycle pulse, dev_addr updated.
REQ-016 dev_rw  output  1  latched rw of current transaction.
REQ-017 dev_wdata  output  DATA_WIDTH  deserialised write data, held.
REQ-018 dev_wdata_valid  output  1  one-cycle pulse, dev_wdata updated.
REQ-019 dev_done  input  1  device finished the write.
REQ-020 dev_rdata  input  DATA_WIDTH  read data from device.
REQ-021 dev_rdata_valid  input  1  dev_rdata valid this cycle.
REQ-022 dev_split_req  input  1  device requests bus split while preparing read data.

Function
REQ-023 FSM states: IDLE, ADDR, WDATA, WR_WAIT, RD_WAIT, RD_TX.
REQ-024 Bit accepted only when bus_data_in_valid=1 and bus_mode matches the phase (1 in IDLE/ADDR, 0 in WDATA); other bits ignored and not counted.
REQ-025 Gaps (valid=0) hold state and bit counter.
REQ-026 IDLE: accepted address bit -> stored at dev_addr[0], bus_init_rw latched into dev_rw, counter=1, go ADDR.
REQ-027 ADDR: accepted bit stored at dev_addr[counter], LSB first; counter increments.
REQ-028 On the edge accepting bit ADDR_WIDTH-1: dev_addr_valid=1 for the following cycle; dev_rw=1 -> WDATA, else RD_WAIT; counter cleared.
REQ-029 WDATA: DATA_WIDTH accepted bits stored LSB first; on the last, dev_wdata_valid pulses one cycle, go WR_WAIT.
REQ-030 WR_WAIT: dev_done=1 -> target_ack pulses one cycle, go IDLE.
REQ-031 RD_WAIT: dev_split_req=1 and dev_rdata_valid=0 -> target_split pulses one cycle (once per rising edge of dev_split_req), remain.
REQ-032 RD_WAIT: dev_rdata_valid=1 -> dev_rdata latched into the transmit register; simultaneous dev_split_req ignored.
REQ-033 Latched data and bus_init_ready=1 -> RD_TX; bus_init_ready=0 -> hold latched data in RD_WAIT.
REQ-034 RD_TX: bus_data_out_valid=1 for exactly DATA_WIDTH consecutive cycles, bus_data_out=bit i in cycle i, LSB first; bus_init_ready ignored once started.
REQ-035 Cycle after the last RD_TX bit: bus_data_out_valid=0, target_ack pulses one cycle, go IDLE.
REQ-036 bus_data_out_valid=0 in every state except RD_TX; bus_data_out=0 when not valid.
REQ-037 bus_data_in bits arriving in WR_WAIT, RD_WAIT or RD_TX are ignored.
REQ-038 All outputs registered; no combinational path from inputs to outputs.

Reset
REQ-039 rst=1 asynchronously forces IDLE, counters 0, all outputs 0, including dev_addr, dev_wdata and dev_rw.
REQ-040 Reset mid-transaction discards partial bits; the first accepted address bit after release starts a new transaction.

Verification
REQ-041 Write: 16 addr bits of 0xA55A LSB first (mode=1, rw=1), then 8 bits of 0x3C (mode=0) -> dev_addr=0xA55A with one dev_addr_valid pulse, dev_wdata=0x3C with one dev_wdata_valid pulse; dev_done -> one target_ack.
REQ-042 Read: addr 0xA55A with rw=0, dev_rdata=0x96 pulsed, bus_init_ready=1 -> bus_data_out_valid for 8 cycles carrying 0,1,1,0,1,0,0,1, then one target_ack.
REQ-043 Read with bus_init_ready=0 for 5 cycles after dev_rdata_valid -> no bus_data_out_valid until ready=1; then the exact 0x96 sequence.
REQ-044 Address with valid=0 gaps and interleaved mode=0 bits -> those bits ignored, dev_addr=0xA55A.
REQ-045 rst asserted after 7 address bits, then full 0x1234 write with data 0xFF -> dev_addr=0x1234, dev_wdata=0xFF, exactly one dev_addr_valid.
REQ-046 dev_split_req held high 3 cycles in RD_WAIT -> exactly one target_split pulse; later dev_rdata=0x5A -> serial 0x5A, one target_ack.
